pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage MIPS core. It collects stall requests from IF, ID, EX and MEM and exception reports from MEM, and drives the 6-bit `stall` vector that every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) consumes. It also drives the flush and exception-redirect signals. A small state machine discards an instruction-SRAM fetch that is still in flight when a flush occurs. Saturating performance counters for stall and flush events are included.

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_sat_counter.sv | 29 ++
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall/flush polarities,
// stall patterns, exception cause codes and controller FSM encodings.
package pipe_ctrl_pkg;

    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;
    localparam logic Flush   = 1'b1;
    localparam logic NoFlush = 1'b0;

    // Bit order: {WB, MEM, EX, ID, IF, PC}; a requesting stage stops itself and everything upstream.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000A;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000D;
    localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000E;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DISCARD = 2'd2
    } ctrl_state_e;

    function automatic logic [5:0] prio_stall(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
        logic [5:0] v;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        else if (req_if) v = STALL_IF;
        else             v = STALL_NONE;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline, with a small FSM that
// tells IF to drop a fetch still in flight across a flush, plus stall/flush event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
    parameter logic [31:0] ERET_TYPE = 32'h0000_000E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] except_type_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        if_discard,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    ctrl_state_e state_d;
    ctrl_state_e state_q;
    logic [5:0]  base_stall;
    logic        exc_accept;

    assign base_stall = prio_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    // MEM keeps holding its exception while its own stall is up, so it is taken once that clears.
    assign exc_accept = (except_type_i != EXC_NONE) && !stallreq_mem;

    always_comb begin
        state_d    = state_q;
        stall      = base_stall;
        flush      = NoFlush;
        new_pc     = 32'h0;
        if_discard = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (exc_accept) begin
                    flush   = Flush;
                    stall   = STALL_NONE;
                    new_pc  = (except_type_i == ERET_TYPE) ? cp0_epc_i : EXC_ENTRY;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if_discard = 1'b1;
                if (stallreq_if) begin
                    stall   = STALL_IF;
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DISCARD: begin
                // The stale fetch returns in the cycle stallreq_if drops; keep discarding through it.
                if_discard = 1'b1;
                stall      = base_stall | STALL_IF;
                if (!stallreq_if) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            state_d    = ST_RUN;
            stall      = STALL_NONE;
            flush      = NoFlush;
            new_pc     = 32'h0;
            if_discard = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (stall != STALL_NONE),
        .cnt_o (stall_cycles)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (flush),
        .cnt_o (flush_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change 1 ns after the rising edge, outputs checked mid-cycle.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] except_type_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        if_discard;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .except_type_i (except_type_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .if_discard    (if_discard),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let the new inputs settle before checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
        stallreq_if  = r_if;
        stallreq_id  = r_id;
        stallreq_ex  = r_ex;
        stallreq_mem = r_mem;
    endtask

    task automatic do_reset();
        set_req(0, 0, 0, 0);
        except_type_i = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        except_type_i = 32'h0;
        cp0_epc_i     = 32'h0;
        set_req(1, 1, 1, 1);
        #1;

        // Reset held for two cycles with every request high.
        settle();
        chk("rst_stall", {26'h0, stall}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_discard", {31'h0, if_discard}, 32'h0);
        step();
        step();
        chk("rst_stall_cnt", stall_cycles, 32'h0);
        chk("rst_flush_cnt", {16'h0, flush_count}, 32'h0);
        rst = 1'b0;
        settle();
        chk("post_rst_stall", {26'h0, stall}, 32'h1F);
        step();
        chk("post_rst_cnt", stall_cycles, 32'h1);

        // Priority: lone IF and lone ID requests.
        set_req(1, 0, 0, 0);
        settle();
        chk("prio_if", {26'h0, stall}, 32'h03);
        set_req(1, 1, 0, 0);
        settle();
        chk("prio_id", {26'h0, stall}, 32'h07);

        // ID and EX together for three cycles.
        do_reset();
        set_req(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("idex_stall%0d", i), {26'h0, stall}, 32'h0F);
            step();
        end
        chk("idex_cnt", stall_cycles, 32'h3);

        // Exception held off by MEM stall, accepted when it drops.
        do_reset();
        except_type_i = 32'h0000_000C;
        set_req(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("exc_hold_flush%0d", i), {31'h0, flush}, 32'h0);
            chk($sformatf("exc_hold_stall%0d", i), {26'h0, stall}, 32'h1F);
            step();
        end
        set_req(0, 0, 0, 0);
        settle();
        chk("exc_flush", {31'h0, flush}, 32'h1);
        chk("exc_newpc", new_pc, 32'hBFC0_0380);
        chk("exc_stall", {26'h0, stall}, 32'h0);
        step();
        chk("exc_flush_cnt", {16'h0, flush_count}, 32'h1);
        // FLUSH state, no IF request, exception still presented must be ignored.
        settle();
        chk("flushst_flush", {31'h0, flush}, 32'h0);
        chk("flushst_discard", {31'h0, if_discard}, 32'h1);
        chk("flushst_stall", {26'h0, stall}, 32'h0);
        except_type_i = 32'h0;
        step();
        settle();
        chk("back_run_discard", {31'h0, if_discard}, 32'h0);
        chk("exc_stall_cnt", stall_cycles, 32'h2);

        // ERET beats an EX stall, then IF keeps stalling across the flush.
        except_type_i = 32'h0000_000E;
        cp0_epc_i     = 32'h8000_1234;
        set_req(0, 0, 1, 0);
        settle();
        chk("eret_flush", {31'h0, flush}, 32'h1);
        chk("eret_stall", {26'h0, stall}, 32'h0);
        chk("eret_newpc", new_pc, 32'h8000_1234);
        step();
        except_type_i = 32'h0;
        set_req(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) except_type_i = 32'h0000_000C;
            settle();
            chk($sformatf("disc_flag%0d", i), {31'h0, if_discard}, 32'h1);
            chk($sformatf("disc_stall%0d", i), {26'h0, stall}, 32'h03);
            chk($sformatf("disc_flush%0d", i), {31'h0, flush}, 32'h0);
            step();
        end
        except_type_i = 32'h0;
        set_req(0, 0, 0, 0);
        settle();
        chk("disc_last_flag", {31'h0, if_discard}, 32'h1);
        chk("disc_last_stall", {26'h0, stall}, 32'h03);
        step();
        settle();
        chk("disc_done_flag", {31'h0, if_discard}, 32'h0);
        chk("disc_done_stall", {26'h0, stall}, 32'h0);
        chk("eret_flush_cnt", {16'h0, flush_count}, 32'h2);

        // Reset taken from DISCARD returns to RUN.
        except_type_i = 32'h0000_0008;
        settle();
        step();
        except_type_i = 32'h0;
        set_req(1, 0, 0, 0);
        step();
        rst = 1'b1;
        settle();
        chk("rst_disc_stall", {26'h0, stall}, 32'h0);
        chk("rst_disc_flag", {31'h0, if_discard}, 32'h0);
        step();
        rst = 1'b0;
        settle();
        chk("rst_disc_run", {31'h0, if_discard}, 32'h0);
        chk("rst_disc_run_stall", {26'h0, stall}, 32'h03);

        // Stall counter saturation from a preloaded value.
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        settle();
        chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk($sformatf("sat_hold%0d", i), stall_cycles, 32'hFFFF_FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
